// File: rtl/sar_scan_scheduler.sv
// Multi-channel SAR conversion scheduler: walks the enable mask, settles the mux,
// starts the ADC core with a watchdog and queues channel-tagged results in a FWFT FIFO.
module sar_scan_scheduler #(
  parameter int N       = 4,
  parameter int CW      = 2,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 32,
  parameter int DEPTH   = 4
) (
  input  logic                 clk_1Mhz,
  input  logic                 reset,
  input  logic [(1<<CW)-1:0]   ch_enable,
  input  logic                 trigger,
  input  logic                 continuous,
  input  logic                 adc_done,
  input  logic [N-1:0]         adc_result,
  input  logic                 res_ready,
  input  logic                 ovf_clr,
  output logic                 adc_start,
  output logic [CW-1:0]        ch_sel,
  output logic                 scan_busy,
  output logic                 res_valid,
  output logic [N-1:0]         res_data,
  output logic [CW-1:0]        res_ch,
  output logic                 overflow,
  output logic                 timeout_err,
  output logic [2:0]           dbg_state
);

  localparam int CH = 1 << CW;
  localparam int PW = CW + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + N;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  ch_sel_q, ch_sel_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic           push, to_set;
  logic           found;
  logic [CW-1:0]  found_idx;

  // Lowest enabled channel at or above ptr; ptr == CH matches nothing.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (ch_enable[i] && (PW'(i) >= ptr_q)) begin
        found     = 1'b1;
        found_idx = CW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ch_sel_d = ch_sel_q;
    scnt_d   = scnt_q;
    wd_d     = wd_q;
    push     = 1'b0;
    to_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((trigger | continuous) & (|ch_enable)) begin
          ptr_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (found) begin
          ch_sel_d = found_idx;
          scnt_d   = SW'(SETTLE - 1);
          state_d  = S_SETTLE;
        end else if (continuous && (|ch_enable)) begin
          ptr_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (scnt_q == '0) state_d = S_START;
        else              scnt_d  = scnt_q - SW'(1);
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the final watchdog cycle still counts as a result.
        if (adc_done) begin
          push    = 1'b1;
          ptr_d   = {1'b0, ch_sel_q} + PW'(1);
          state_d = S_SELECT;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          to_set  = 1'b1;
          ptr_d   = {1'b0, ch_sel_q} + PW'(1);
          state_d = S_SELECT;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1Mhz or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      ch_sel_q <= '0;
      scnt_q   <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ch_sel_q <= ch_sel_d;
      scnt_q   <= scnt_d;
      wd_q     <= wd_d;
    end
  end

  assign adc_start = (state_q == S_START);
  assign scan_busy = (state_q != S_IDLE);
  assign ch_sel    = ch_sel_q;
  assign dbg_state = state_q;

  // Result handshake: an entry transfers on a cycle where res_valid and res_ready are
  // both high; res_data/res_ch hold steady while res_valid is high and res_ready is low.
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          full, pop, push_ok, drop;
  logic          overflow_q, timeout_q;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid & res_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk_1Mhz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= {ch_sel_q, adc_result};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign res_data = mem_q[rd_q][N-1:0];
  assign res_ch   = mem_q[rd_q][EW-1:N];

  // Sticky flags: a set event in the same cycle as ovf_clr takes precedence.
  always_ff @(posedge clk_1Mhz or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      if (to_set)       timeout_q  <= 1'b1;
      else if (ovf_clr) timeout_q  <= 1'b0;
    end
  end

  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sar_scan_scheduler.sv
// Directed bench for sar_scan_scheduler: behavioural ADC core model, expected-result queue,
// hand-timed checks for settle/start timing, overflow, watchdog, async reset and empty mask.
module tb_sar_scan_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] ch_enable;
  logic       trigger, continuous, res_ready, ovf_clr;
  logic       adc_done;
  logic [3:0] adc_result;
  logic       adc_start, scan_busy, res_valid, overflow, timeout_err;
  logic [1:0] ch_sel, res_ch;
  logic [3:0] res_data;
  logic [2:0] dbg_state;

  logic       model_done, man_done, adc_hold;
  logic [3:0] model_result, man_result;
  logic [3:0] code_q[$];
  logic [5:0] exp_q[$];
  logic [5:0] exp_e;
  int         n_chk, n_pass, start_cnt, start_base;

  assign adc_done   = model_done | man_done;
  assign adc_result = man_done ? man_result : model_result;

  sar_scan_scheduler #(.N(4), .CW(2), .SETTLE(2), .TIMEOUT(16), .DEPTH(4)) dut (
    .clk_1Mhz    (clk),
    .reset       (reset),
    .ch_enable   (ch_enable),
    .trigger     (trigger),
    .continuous  (continuous),
    .adc_done    (adc_done),
    .adc_result  (adc_result),
    .res_ready   (res_ready),
    .ovf_clr     (ovf_clr),
    .adc_start   (adc_start),
    .ch_sel      (ch_sel),
    .scan_busy   (scan_busy),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ch      (res_ch),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ADC core model: done with the next queued code two cycles after a start
  initial begin
    model_done   = 1'b0;
    model_result = 4'h0;
    forever begin
      @(negedge clk);
      if (adc_start && !adc_hold) begin
        repeat (2) @(negedge clk);
        model_result = (code_q.size() > 0) ? code_q.pop_front() : 4'h0;
        model_done   = 1'b1;
        @(negedge clk);
        model_done   = 1'b0;
      end
    end
  end

  initial start_cnt = 0;
  always @(negedge clk) if (adc_start === 1'b1) start_cnt = start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (adc_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, adc_start, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, res_valid, 1);
  endtask

  task automatic chk_head(input string tag);
    exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
    chk({tag, "_ch"},   res_ch,   exp_e[5:4]);
    chk({tag, "_data"}, res_data, exp_e[3:0]);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; ch_enable = 4'b0000; trigger = 1'b0; continuous = 1'b0;
    res_ready = 1'b0; ovf_clr = 1'b0; adc_hold = 1'b0;
    man_done = 1'b0; man_result = 4'h0;

    // Reset state
    tick(2);
    chk("rst_busy", scan_busy, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_chsel", ch_sel, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout_err, 0);
    reset = 1'b1;
    tick(2);
    chk("idle_state", dbg_state, 0);

    // Settle timing: trigger driven after edge 0
    ch_enable = 4'b0001; res_ready = 1'b1;
    code_q.push_back(4'h7); exp_q.push_back({2'd0, 4'h7});
    start_base = start_cnt;
    trigger = 1'b1;
    tick(1); trigger = 1'b0;                    // after edge 1
    chk("st_select", dbg_state, 1);
    chk("st_busy", scan_busy, 1);
    tick(1);                                    // after edge 2
    chk("st_chsel", ch_sel, 0);
    chk("st_settle", dbg_state, 2);
    chk("st_nostart_e2", adc_start, 0);
    tick(1);                                    // after edge 3
    chk("st_nostart_e3", adc_start, 0);
    tick(1);                                    // after edge 4
    chk("st_start_e4", adc_start, 1);
    tick(1);                                    // after edge 5
    chk("st_nostart_e5", adc_start, 0);
    chk("st_wait", dbg_state, 4);
    tick(1);                                    // after edge 6: done driven now
    chk("st_novalid_e6", res_valid, 0);
    tick(1);                                    // after edge 7: pushed
    chk("st_valid_e7", res_valid, 1);
    chk_head("st_res");
    tick(1);
    chk("st_popped", res_valid, 0);
    chk("st_idle", scan_busy, 0);
    chk("st_nstarts", start_cnt - start_base, 1);

    // Single scan, sparse mask
    ch_enable = 4'b1010;
    code_q.push_back(4'hA); code_q.push_back(4'h5);
    exp_q.push_back({2'd1, 4'hA}); exp_q.push_back({2'd3, 4'h5});
    start_base = start_cnt;
    pulse_trigger();
    wait_start("sp1");
    chk("sp1_chsel", ch_sel, 1);
    wait_valid("sp1");
    chk_head("sp1_res");
    wait_start("sp2");
    chk("sp2_chsel", ch_sel, 3);
    wait_valid("sp2");
    chk_head("sp2_res");
    tick(2);
    chk("sp_busy_low", scan_busy, 0);
    chk("sp_idle", dbg_state, 0);
    chk("sp_nstarts", start_cnt - start_base, 2);
    chk("sp_empty", res_valid, 0);

    // Overflow: five conversions into a four-entry FIFO with no consumer
    res_ready = 1'b0; ch_enable = 4'b0001;
    for (int i = 1; i <= 6; i++) code_q.push_back(4'(i));
    for (int i = 1; i <= 4; i++) exp_q.push_back({2'd0, 4'(i)});
    continuous = 1'b1;
    begin
      int n;
      n = 0;
      while (overflow !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    continuous = 1'b0;
    chk("ov_set", overflow, 1);
    chk("ov_valid", res_valid, 1);
    chk("ov_head", res_data, 1);
    tick(3);
    chk("ov_idle", scan_busy, 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ov_clr", overflow, 0);
    // Push while full coinciding with a pop must be accepted
    pulse_trigger();
    begin
      int n;
      n = 0;
      @(negedge clk); #1;
      while (adc_done !== 1'b1 && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
      chk("ov_done_seen", adc_done, 1);
    end
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({2'd0, 4'h6});
    chk("ov_popush_noovf", overflow, 0);
    chk("ov_popush_valid", res_valid, 1);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ov_drain_valid", res_valid, 1);
      chk_head("ov_drain");
      tick(1);
    end
    chk("ov_drained", res_valid, 0);

    // Watchdog on channel 0, channel 1 converts normally afterwards
    adc_hold = 1'b1; ch_enable = 4'b0011;
    code_q.push_back(4'h9); exp_q.push_back({2'd1, 4'h9});
    pulse_trigger();
    wait_start("wd0");
    chk("wd0_chsel", ch_sel, 0);
    tick(16);
    chk("wd_not_yet", timeout_err, 0);
    chk("wd_in_wait", dbg_state, 4);
    tick(1);
    chk("wd_set", timeout_err, 1);
    chk("wd_no_entry", res_valid, 0);
    chk("wd_to_select", dbg_state, 1);
    adc_hold = 1'b0;
    wait_start("wd1");
    chk("wd1_chsel", ch_sel, 1);
    wait_valid("wd1");
    chk_head("wd1_res");
    tick(3);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("wd_clr", timeout_err, 0);

    // Asynchronous reset mid-WAIT
    adc_hold = 1'b1; ch_enable = 4'b0001;
    pulse_trigger();
    wait_start("ar");
    tick(3);
    chk("ar_in_wait", dbg_state, 4);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", scan_busy, 0);
    chk("ar_state", dbg_state, 0);
    chk("ar_chsel", ch_sel, 0);
    chk("ar_data", res_data, 0);
    chk("ar_ch", res_ch, 0);
    chk("ar_valid", res_valid, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    man_result = 4'hF; man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(1);
    chk("ar_late_done", res_valid, 0);
    chk("ar_still_idle", scan_busy, 0);
    adc_hold = 1'b0;

    // Empty mask: neither trigger nor continuous starts a scan
    ch_enable = 4'b0000;
    start_base = start_cnt;
    trigger = 1'b1; continuous = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("em_busy", scan_busy, 0);
    end
    trigger = 1'b0; continuous = 1'b0;
    tick(1);
    chk("em_nostart", start_cnt - start_base, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sar_scan_scheduler.md
# sar_scan_scheduler

Multi-channel conversion scheduler for the SAR ADC core. It walks an enabled-channel mask, drives the analog input mux select, and waits a programmable settling time. It then pulses the ADC core's start, waits for its done/result with a watchdog, and buffers tagged results in a small first-word-fall-through FIFO. The block sits between the ADC core and the readout logic, in the same `clk_1Mhz` domain.

## Interface
- `N`, 4: ADC resolution in bits (width of `adc_result` and `res_data`).
- `CW`, 2: channel index width; channel count `CH = 1<<CW`.
- `SETTLE`, 2: mux settling cycles before each start; must be ≥1.
- `TIMEOUT`, 32: maximum cycles in WAIT before the conversion is abandoned.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.

- `clk_1Mhz`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ch_enable`  in  CH  per-channel enable mask; sampled in SELECT.
- `trigger`  in  1  single-scan request; sampled only in IDLE.
- `continuous`  in  1  when high, scans repeat back-to-back.
- `adc_done`  in  1  one-cycle pulse from the ADC core; `adc_result` is valid in the same cycle.
- `adc_result`  in  N  conversion code.
- `res_ready`  in  1  consumer accepts the FIFO head.
- `ovf_clr`  in  1  clears `overflow` and `timeout_err`.
- `adc_start`  out  1  one-cycle start pulse to the ADC core.
- `ch_sel`  out  CW  mux select; registered.
- `scan_busy`  out  1  high in every state except IDLE.
- `res_valid`  out  1  FIFO not empty.
- `res_data`  out  N  FIFO head code.
- `res_ch`  out  CW  FIFO head channel tag.
- `overflow`  out  1  sticky: a result was dropped because the FIFO was full.
- `timeout_err`  out  1  sticky: a WAIT state expired.

## Operation
- States: IDLE, SELECT, SETTLE, START, WAIT.
- **IDLE**
  - If `(trigger | continuous) & |ch_enable`, set `ptr=0` and go to SELECT.
  - Otherwise remain in IDLE.
- **SELECT**
  - Find the lowest `i ≥ ptr` with `ch_enable[i]=1`.
  - If found: `ch_sel<=i`, load the settle counter, go to SETTLE.
  - If none, the scan is complete:
    - `continuous=1` and `|ch_enable`: set `ptr=0`, stay in SELECT.
    - Otherwise go to IDLE.
- **SETTLE**: count `SETTLE` cycles, then go to START.
- **START**: `adc_start=1` for this cycle only; clear the watchdog; go to WAIT.
- **WAIT**
  - On `adc_done`: push `{ch_sel, adc_result}`, set `ptr=ch_sel+1`, go to SELECT.
  - When the watchdog reaches `TIMEOUT` with no `adc_done`: set `timeout_err`, push nothing, set `ptr=ch_sel+1`, go to SELECT.
- **ptr wrap**: `ptr=CH` (held in CW+1 bits) means no channel remains in this scan.
- **Mid-scan input changes**
  - `trigger` is ignored outside IDLE.
  - Deasserting `continuous` mid-scan: the current scan finishes, then the block returns to IDLE.
  - `ch_enable` changes take effect at the next SELECT.
- **FIFO**
  - Pop on `res_valid & res_ready`.
  - Push while full and no pop in the same cycle: drop the entry, set `overflow`.
  - Push while full with a pop in the same cycle: the push is accepted, `overflow` is unchanged.
  - Push while empty with `res_ready=1`: the entry appears next cycle.
- **Sticky flags**
  - `ovf_clr` clears both `overflow` and `timeout_err`.
  - If a set event and `ovf_clr` occur in the same cycle, the set wins.

## Timing
- **Reset** (asynchronous, immediate)
  - Every output goes to 0.
  - State=IDLE, `ptr=0`, FIFO empty.
  - Reset mid-WAIT abandons the conversion, and any late `adc_done` arriving in IDLE is ignored.
- **Trigger to start**: `trigger` sampled at edge k gives SELECT at k+1 and `ch_sel` valid from k+2. `adc_start` is high for exactly the cycle following edge k+2+SETTLE.
- **Between channels**: from `adc_done` at edge m, the next `ch_sel` is valid at m+2 and the next `adc_start` follows edge m+2+SETTLE.
- **Result latency**: `adc_done` at edge m sets `res_valid` (if it was empty) from m+1. `res_data`/`res_ch` are registered head values, holding 0 after reset until the first push.
- **Timeout**: `timeout_err` sets on the edge ending the `TIMEOUT`-th WAIT cycle.

## Test plan
- **Single scan, sparse mask**
  - Stimulus: `ch_enable=4'b1010`, `trigger` pulse, ADC core model returns `4'hA` then `4'h5`, `res_ready=1`.
  - Response: `ch_sel` 1 then 3, two `adc_start` pulses, results `{1,A}` and `{3,5}` delivered, `scan_busy` falls, back in IDLE.
- **Settle timing**
  - Stimulus: `SETTLE=2`, `trigger` at edge 0.
  - Response: `adc_start` high only in the cycle after edge 4; `ch_sel=0` from edge 2.
- **Overflow**
  - Stimulus: `DEPTH=4`, `res_ready=0`, `continuous=1`, `ch_enable=4'b0001`, five conversions.
  - Response: four entries retained, fifth dropped, `overflow=1`.
  - Follow-up: pulse `ovf_clr` → `overflow=0`. Pop and push in the same cycle while full → no overflow.
- **Watchdog**
  - Stimulus: `TIMEOUT=16`, `adc_done` withheld on channel 0, `ch_enable=4'b0011`.
  - Response: `timeout_err=1` after 16 WAIT cycles, no entry for channel 0, then channel 1 converts normally.
- **Asynchronous reset mid-WAIT**
  - Stimulus: assert `reset` low between clock edges.
  - Response: all outputs 0 immediately, FIFO empty; a later `adc_done` creates no entry.
- **Empty mask**
  - Stimulus: `ch_enable=0` with `trigger` or `continuous`.
  - Response: no `adc_start`, `scan_busy` stays 0.
